// File: rtl/keyfetch_pkg.sv
// ---------------------------------------------------------------------------
// keyfetch_pkg
// Shared definitions for the key fetch engine: FSM state encoding and the
// derivation of ROM word count / transfer count from the ROM byte size.
// No ports (package).
// ---------------------------------------------------------------------------
package keyfetch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        FILL  = 3'd3,
        OUT   = 3'd4
    } kf_state_t;

    // 16-bit words held by a ROM of mem_size bytes
    function automatic int unsigned kf_words(input int unsigned mem_size);
        return mem_size / 2;
    endfunction

    // 32-bit transfers needed to stream every word (last may be half-filled)
    function automatic int unsigned kf_xfers(input int unsigned mem_size);
        return (kf_words(mem_size) + 1) / 2;
    endfunction

    // Width of the transfer counter; at least one bit
    function automatic int unsigned kf_cnt_width(input int unsigned xfers);
        return (xfers > 1) ? $clog2(xfers) : 1;
    endfunction

endpackage

// File: rtl/key_fetch.sv
// ---------------------------------------------------------------------------
// key_fetch
// Streams the whole key ROM to a downstream consumer as packed 32-bit words
// (low half = even word, high half = odd word, zero-filled past the end).
//
// Ports
//   mclk       in   clock, rising edge
//   puc_rst    in   synchronous active-high reset
//   start      in   begin a fetch (honoured only when idle)
//   abort      in   cancel the current fetch
//   rom_addr   out  key ROM word address
//   rom_cen    out  key ROM chip enable, active-low
//   rom_dout   in   key ROM data, valid the cycle after a read
//   key_data   out  packed key word
//   key_valid  out  key_data valid
//   key_ready  in   consumer accepts key_data
//   key_last   out  final transfer marker
//   busy       out  fetch in progress
//   done       out  one-cycle pulse after the final accepted transfer
// ---------------------------------------------------------------------------
module key_fetch
    import keyfetch_pkg::*;
#(
    parameter int ADDR_MSB = 4,
    parameter int MEM_SIZE = 20
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_MSB:0] rom_addr,
    output logic              rom_cen,
    input  logic [15:0]       rom_dout,
    output logic [31:0]       key_data,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              key_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned WORDS = kf_words(MEM_SIZE);
    localparam int unsigned XFERS = kf_xfers(MEM_SIZE);
    localparam int unsigned KW    = kf_cnt_width(XFERS);
    localparam int unsigned AW    = ADDR_MSB + 1;

    kf_state_t      r_state;
    kf_state_t      w_next;
    logic [KW-1:0]  r_k;
    logic [31:0]    r_key_data;
    logic           r_done;

    logic [31:0]    w_lo_word;
    logic           w_has_hi;
    logic           w_last;
    logic [AW-1:0]  w_lo_addr;
    logic [AW-1:0]  w_hi_addr;

    assign w_lo_word = 32'(r_k) << 1;
    assign w_has_hi  = (w_lo_word + 32'd1) < 32'(WORDS);
    assign w_last    = (r_k == KW'(XFERS - 1));
    assign w_lo_addr = AW'(w_lo_word);
    assign w_hi_addr = AW'(w_lo_word + 32'd1);

    // State register
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every transition
    always_comb begin
        w_next = r_state;
        if (abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start) w_next = RD_LO;
                RD_LO:   w_next = RD_HI;
                RD_HI:   w_next = FILL;
                FILL:    w_next = OUT;
                OUT:     if (key_ready) w_next = w_last ? IDLE : RD_LO;
                default: w_next = IDLE;
            endcase
        end
    end

    // Transfer counter, key assembly and done pulse
    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            r_k        <= '0;
            r_key_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (abort) begin
                r_k        <= '0;
                r_key_data <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_k        <= '0;
                        r_key_data <= '0;
                    end
                    RD_HI: r_key_data[15:0] <= rom_dout;
                    FILL:  r_key_data[31:16] <= w_has_hi ? rom_dout : 16'h0000;
                    OUT: begin
                        if (key_ready) begin
                            if (w_last) begin
                                r_k        <= '0;
                                r_key_data <= '0;
                                r_done     <= 1'b1;
                            end else begin
                                r_k <= r_k + KW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs; reset forces idle values even before the clock edge lands
    always_comb begin
        rom_cen   = 1'b1;
        rom_addr  = '0;
        key_valid = 1'b0;
        key_last  = 1'b0;
        busy      = 1'b0;
        key_data  = '0;
        done      = 1'b0;
        if (!puc_rst) begin
            busy     = (r_state != IDLE);
            key_data = r_key_data;
            done     = r_done;
            case (r_state)
                RD_LO: begin
                    rom_cen  = 1'b0;
                    rom_addr = w_lo_addr;
                end
                RD_HI: begin
                    if (w_has_hi) begin
                        rom_cen  = 1'b0;
                        rom_addr = w_hi_addr;
                    end
                end
                OUT: begin
                    key_valid = 1'b1;
                    key_last  = w_last;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_fetch.sv
// ---------------------------------------------------------------------------
// tb_key_fetch
// Directed bench for key_fetch: a 20-byte instance and an 18-byte instance,
// each with a behavioural key ROM (one-cycle read latency).
// ---------------------------------------------------------------------------
module tb_key_fetch;

    logic        mclk = 1'b0;
    always #5 mclk = ~mclk;

    logic        puc_rst = 1'b1;
    logic        abort   = 1'b0;

    // 20-byte instance
    logic        start = 1'b0;
    logic        key_ready = 1'b0;
    logic [4:0]  rom_addr;
    logic        rom_cen;
    logic [15:0] rom_dout = '0;
    logic [31:0] key_data;
    logic        key_valid, key_last, busy, done;

    // 18-byte instance
    logic        start2 = 1'b0;
    logic        ready2 = 1'b0;
    logic [4:0]  rom_addr2;
    logic        rom_cen2;
    logic [15:0] rom_dout2 = '0;
    logic [31:0] key_data2;
    logic        key_valid2, key_last2, busy2, done2;

    logic [15:0] mem1 [0:31];
    logic [15:0] mem2 [0:31];

    int n_chk  = 0;
    int n_pass = 0;
    int n_oob1 = 0;
    int n_oob2 = 0;

    localparam logic [31:0] EXP_SEQ [0:4] = '{
        32'h0001_0000, 32'h0003_0002, 32'h0005_0004,
        32'h0007_0006, 32'h0009_0008
    };

    key_fetch #(.ADDR_MSB(4), .MEM_SIZE(20)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
        .rom_addr(rom_addr), .rom_cen(rom_cen), .rom_dout(rom_dout),
        .key_data(key_data), .key_valid(key_valid), .key_ready(key_ready),
        .key_last(key_last), .busy(busy), .done(done)
    );

    key_fetch #(.ADDR_MSB(4), .MEM_SIZE(18)) dut18 (
        .mclk(mclk), .puc_rst(puc_rst), .start(start2), .abort(abort),
        .rom_addr(rom_addr2), .rom_cen(rom_cen2), .rom_dout(rom_dout2),
        .key_data(key_data2), .key_valid(key_valid2), .key_ready(ready2),
        .key_last(key_last2), .busy(busy2), .done(done2)
    );

    // Key ROM models and out-of-range read monitors
    always @(posedge mclk) begin
        if (!rom_cen) rom_dout <= mem1[rom_addr];
        if (!rom_cen && rom_addr > 5'd9) n_oob1 <= n_oob1 + 1;
    end
    always @(posedge mclk) begin
        if (!rom_cen2) rom_dout2 <= mem2[rom_addr2];
        if (!rom_cen2 && rom_addr2 > 5'd8) n_oob2 <= n_oob2 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge mclk);
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!key_valid && cyc < 20);
        chk("valid_seen", 32'(key_valid), 32'd1);
    endtask

    task automatic wait_valid2(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!key_valid2 && cyc < 20);
        chk("valid2_seen", 32'(key_valid2), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cen"},   32'(rom_cen),   32'd1);
        chk({tag, "_addr"},  32'(rom_addr),  32'd0);
        chk({tag, "_data"},  key_data,       32'd0);
        chk({tag, "_valid"}, 32'(key_valid), 32'd0);
        chk({tag, "_last"},  32'(key_last),  32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int seen_done;

        for (int i = 0; i < 32; i++) begin
            mem1[i] = 16'hcccc;
            mem2[i] = 16'(i);
        end

        // Reset state
        tick();
        tick();
        chk_idle_outputs("rst");
        puc_rst = 1'b0;
        tick();
        chk_idle_outputs("post_rst");

        // Constant pattern, ready held high
        key_ready = 1'b1;
        start_pulse();
        for (int t = 0; t < 5; t++) begin
            wait_valid(cyc);
            chk("cc_latency", 32'(cyc), (t == 0) ? 32'd3 : 32'd4);
            chk("cc_data",    key_data, 32'hcccc_cccc);
            chk("cc_last",    32'(key_last), (t == 4) ? 32'd1 : 32'd0);
            chk("cc_cen_out", 32'(rom_cen), 32'd1);
        end
        tick();
        chk("cc_done",      32'(done), 32'd1);
        chk("cc_busy_done", 32'(busy), 32'd0);
        chk("cc_data_clr",  key_data,  32'd0);
        tick();
        chk("cc_done_pulse", 32'(done), 32'd0);

        // Counting pattern, ready toggled
        for (int i = 0; i < 32; i++) mem1[i] = 16'(i);
        key_ready = 1'b0;
        start_pulse();
        for (int t = 0; t < 5; t++) begin
            wait_valid(cyc);
            chk("seq_data", key_data, EXP_SEQ[t]);
            chk("seq_last", 32'(key_last), (t == 4) ? 32'd1 : 32'd0);
            tick();
            chk("seq_hold_valid", 32'(key_valid), 32'd1);
            chk("seq_hold_data",  key_data, EXP_SEQ[t]);
            chk("seq_hold_last",  32'(key_last), (t == 4) ? 32'd1 : 32'd0);
            key_ready = 1'b1;
            tick();
            key_ready = 1'b0;
            chk("seq_valid_drop", 32'(key_valid), 32'd0);
        end
        chk("seq_done", 32'(done), 32'd1);

        // Odd word count: last transfer's high half zero-filled
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        for (int t = 0; t < 4; t++) begin
            wait_valid2(cyc);
            chk("odd_data", key_data2, EXP_SEQ[t]);
        end
        tick();
        chk("odd_rdlo_cen",  32'(rom_cen2),  32'd0);
        chk("odd_rdlo_addr", 32'(rom_addr2), 32'd8);
        tick();
        chk("odd_rdhi_cen",  32'(rom_cen2),  32'd1);
        tick();
        chk("odd_fill_cen",  32'(rom_cen2),  32'd1);
        tick();
        chk("odd_valid", 32'(key_valid2), 32'd1);
        chk("odd_data5", key_data2, 32'h0000_0008);
        chk("odd_last",  32'(key_last2), 32'd1);
        tick();
        chk("odd_done",  32'(done2), 32'd1);
        chk("odd_no_oob", 32'(n_oob2), 32'd0);
        ready2 = 1'b0;

        // Abort in OUT of the second transfer
        key_ready = 1'b0;
        start_pulse();
        wait_valid(cyc);
        chk("ab_data0", key_data, EXP_SEQ[0]);
        key_ready = 1'b1;
        tick();
        key_ready = 1'b0;
        wait_valid(cyc);
        chk("ab_data1", key_data, EXP_SEQ[1]);
        abort = 1'b1;
        key_ready = 1'b1;
        tick();
        abort = 1'b0;
        key_ready = 1'b0;
        chk("ab_valid", 32'(key_valid), 32'd0);
        chk("ab_data",  key_data,       32'd0);
        chk("ab_cen",   32'(rom_cen),   32'd1);
        chk("ab_busy",  32'(busy),      32'd0);
        seen_done = 0;
        for (int i = 0; i < 4; i++) begin
            if (done) seen_done++;
            tick();
        end
        chk("ab_no_done", 32'(seen_done), 32'd0);
        start_pulse();
        chk("ab_restart_cen",  32'(rom_cen),  32'd0);
        chk("ab_restart_addr", 32'(rom_addr), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort and start together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("as_busy", 32'(busy),    32'd0);
        chk("as_cen",  32'(rom_cen), 32'd1);
        tick();
        chk("as_busy2", 32'(busy), 32'd0);

        // Reset in RD_HI with start held high
        key_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("rr_rdlo_addr", 32'(rom_addr), 32'd0);
        tick();
        chk("rr_rdhi_cen",  32'(rom_cen),  32'd0);
        chk("rr_rdhi_addr", 32'(rom_addr), 32'd1);
        puc_rst = 1'b1;
        tick();
        chk_idle_outputs("rr_rst1");
        tick();
        chk_idle_outputs("rr_rst2");
        puc_rst = 1'b0;
        tick();
        chk("rr_restart_busy", 32'(busy),     32'd1);
        chk("rr_restart_cen",  32'(rom_cen),  32'd0);
        chk("rr_restart_addr", 32'(rom_addr), 32'd0);
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();

        chk("no_oob", 32'(n_oob1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/key_fetch.md
KEY_FETCH -- requirements
Module: key_fetch

Interface
REQ-001 Parameter ADDR_MSB, default 4: MSB of the key ROM word address bus.
REQ-002 Parameter MEM_SIZE, default 20: key ROM size in bytes; WORDS = MEM_SIZE/2; XFERS = ceil(WORDS/2).
REQ-003 mclk  in  1  sole clock; all state changes on its rising edge.
REQ-004 puc_rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request to stream the whole key; sampled only in IDLE.
REQ-006 abort  in  1  cancel the current fetch; sampled in every state.
REQ-007 rom_addr  out  ADDR_MSB+1  key ROM word address.
REQ-008 rom_cen  out  1  key ROM chip enable, active-low.
REQ-009 rom_dout  in  16  key ROM data; valid the cycle after a read is issued.
REQ-010 key_data  out  32  packed key word: [15:0] = mem[2k], [31:16] = mem[2k+1].
REQ-011 key_valid  out  1  key_data valid for transfer k.
REQ-012 key_ready  in  1  downstream (HMAC) accepts key_data.
REQ-013 key_last  out  1  high with key_valid on transfer XFERS-1.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse after the final accepted transfer.

Function
REQ-016 The FSM SHALL have states IDLE, RD_LO, RD_HI, FILL and OUT, plus a transfer counter k of width clog2(XFERS).
REQ-017 IDLE: rom_cen=1; on start, go to RD_LO with k=0.
REQ-018 RD_LO: rom_cen=0, rom_addr=2k; go to RD_HI.
REQ-019 RD_HI: capture rom_dout into key_data[15:0].
REQ-020 RD_HI when 2k+1<WORDS: rom_cen=0, rom_addr=2k+1.
REQ-021 RD_HI when 2k+1>=WORDS: rom_cen=1; the high half SHALL be zero-filled.
REQ-022 RD_HI SHALL always go to FILL.
REQ-023 FILL: capture rom_dout into key_data[31:16], or 0 when zero-filled; rom_cen=1; go to OUT.
REQ-024 OUT: key_valid=1, rom_cen=1; key_last=1 iff k==XFERS-1.
REQ-025 OUT: key_data, key_valid and key_last SHALL hold stable until key_valid&key_ready.
REQ-026 On handshake when not last: k+1 and go to RD_LO.
REQ-027 On handshake when last: go to IDLE and pulse done in the following cycle.
REQ-028 Latency: start sampled in cycle 0 -> key_valid in cycle 3; with key_ready held high, each following transfer takes 4 cycles.
REQ-029 rom_cen SHALL be low only in RD_LO and RD_HI; rom_addr SHALL never exceed WORDS-1.
REQ-030 start in any state other than IDLE SHALL be ignored.
REQ-031 abort in any state: next state IDLE, key_valid=0, key_data cleared to 0, rom_cen=1, no done pulse.
REQ-032 abort together with start in IDLE: abort wins and no fetch begins.
REQ-033 key_data SHALL be cleared to 0 on every entry to IDLE (key hygiene).
REQ-034 key_ready while key_valid=0 SHALL have no effect.

Reset
REQ-035 puc_rst=1 at a clock edge SHALL force IDLE and k=0.
REQ-036 During reset: rom_cen=1, rom_addr=0, key_data=0, key_valid=0, key_last=0, busy=0, done=0.
REQ-037 Reset mid-fetch SHALL behave as abort and take priority over abort, start and key_ready.

Structure
REQ-038 The state encoding and the WORDS/XFERS derivation SHALL live in the shared package keyfetch_pkg.
REQ-039 The block SHALL be a single module with no sub-module; keyrom is instantiated beside it at the parent level.

Verification
REQ-040 ROM = 16'hcccc x10, start pulse, key_ready=1:
- five transfers of 32'hcccccccc, each 4 cycles apart;
- key_last on the 5th;
- done one cycle after the last;
- busy drops with done.
REQ-041 ROM = 0x0000..0x0009 (mem[i]=i), key_ready toggled 1/0: key_data sequence is 0x00010000, 0x00030002, 0x00050004, 0x00070006, 0x00090008, each held stable while ready=0.
REQ-042 MEM_SIZE=18, ROM mem[i]=i: 5th transfer is 0x00000008; rom_addr never reaches 9; rom_cen stays high in that transfer's RD_HI.
REQ-043 abort asserted while in OUT of transfer 2:
- next cycle key_valid=0, key_data=0, rom_cen=1;
- no done pulse;
- a new start restarts from rom_addr=0.
REQ-044 puc_rst asserted in RD_HI, start held high throughout and during reset: all outputs reach reset values; the fetch restarts only after reset deasserts, at rom_addr=0.
